// File: rtl/speck_iter_core_if.sv
// rtl/speck_iter_core_if.sv - host handshake bundle for the iterative SPECK core
interface speck_iter_core_if #(
  parameter int WORD_W    = 64,
  parameter int KEY_WORDS = 2,
  parameter int ROUNDS    = 32
);
  localparam int IDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  logic                          start;
  logic [KEY_WORDS*WORD_W-1:0]   key;
  logic [2*WORD_W-1:0]           plaintext;
  logic [2*WORD_W-1:0]           ciphertext;
  logic                          busy;
  logic                          done;
  logic [IDX_W-1:0]              round_idx;

  modport master (
    output start, key, plaintext,
    input  ciphertext, busy, done, round_idx
  );

  modport slave (
    input  start, key, plaintext,
    output ciphertext, busy, done, round_idx
  );
endinterface

// File: rtl/speck_iter_core.sv
// rtl/speck_iter_core.sv - one-round-per-clock SPECK encryptor with on-the-fly key expansion
module speck_iter_core #(
  parameter int WORD_W    = 64,
  parameter int KEY_WORDS = 2,
  parameter int ROUNDS    = 32,
  parameter int ALPHA     = 8,
  parameter int BETA      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  speck_iter_core_if.slave  bus
);
  localparam int IDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int LW    = KEY_WORDS - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   x_q, y_q, k_q;
  logic [WORD_W-1:0]   l_q [LW];
  logic [IDX_W-1:0]    round_q;
  logic [2*WORD_W-1:0] ct_q;
  logic                busy_q, done_q;

  logic                load, step, last;
  logic [WORD_W-1:0]   x_nx, y_nx, k_nx, l_new;

  // Constant shift amounts, so these reduce to wiring.
  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int s);
    return (v >> s) | (v << (WORD_W - s));
  endfunction

  function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int s);
    return (v << s) | (v >> (WORD_W - s));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (round_q == LAST_IDX) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    step = 1'b0;
    last = 1'b0;
    case (state_q)
      S_IDLE:  load = bus.start;
      S_RUN: begin
        step = 1'b1;
        last = (round_q == LAST_IDX);
      end
      default: ;
    endcase
  end

  // Round function and key schedule share the round index as the schedule constant.
  always_comb begin
    x_nx  = (ror(x_q, ALPHA) + y_q) ^ k_q;
    y_nx  = rol(y_q, BETA) ^ x_nx;
    l_new = (k_q + ror(l_q[0], ALPHA)) ^ WORD_W'(round_q);
    k_nx  = rol(k_q, BETA) ^ l_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      round_q <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int j = 0; j < LW; j++) l_q[j] <= '0;
    end else begin
      done_q <= last;
      if (load) begin
        x_q     <= bus.plaintext[2*WORD_W-1:WORD_W];
        y_q     <= bus.plaintext[WORD_W-1:0];
        k_q     <= bus.key[WORD_W-1:0];
        round_q <= '0;
        busy_q  <= 1'b1;
        for (int j = 0; j < LW; j++) l_q[j] <= bus.key[(j+1)*WORD_W +: WORD_W];
      end else if (step) begin
        x_q <= x_nx;
        y_q <= y_nx;
        k_q <= k_nx;
        for (int j = 0; j < LW - 1; j++) l_q[j] <= l_q[j+1];
        l_q[LW-1] <= l_new;
        if (last) begin
          ct_q    <= {x_nx, y_nx};
          busy_q  <= 1'b0;
          round_q <= '0;
        end else begin
          round_q <= round_q + 1'b1;
        end
      end
    end
  end

  assign bus.ciphertext = ct_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.round_idx  = round_q;
endmodule

// File: tb/tb_speck_iter_core.sv
// tb/tb_speck_iter_core.sv - scoreboard bench for speck_iter_core (128/128 and 32/64)
module tb_speck_iter_core;
  localparam logic [127:0] VEC1_KEY = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
  localparam logic [127:0] VEC1_PT  = {64'h6c61766975716520, 64'h7469206564616d20};
  localparam logic [127:0] VEC1_CT  = {64'ha65d985179783265, 64'h7860fedf5c570d18};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [127:0] sb64 [$];
  logic [31:0]  sb16 [$];

  always #5 clk = ~clk;

  speck_iter_core_if #(.WORD_W(64), .KEY_WORDS(2), .ROUNDS(32)) bus64 ();
  speck_iter_core_if #(.WORD_W(16), .KEY_WORDS(4), .ROUNDS(22)) bus16 ();

  speck_iter_core #(.WORD_W(64), .KEY_WORDS(2), .ROUNDS(32), .ALPHA(8), .BETA(3)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64)
  );
  speck_iter_core #(.WORD_W(16), .KEY_WORDS(4), .ROUNDS(22), .ALPHA(7), .BETA(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [63:0] ror64(input logic [63:0] v, input int s);
    logic [127:0] d;
    d = {v, v} >> s;
    return d[63:0];
  endfunction

  function automatic logic [63:0] rol64(input logic [63:0] v, input int s);
    return ror64(v, 64 - s);
  endfunction

  // Reference: full key schedule first, then the 32 rounds.
  function automatic logic [127:0] speck128_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [63:0] rk [32];
    logic [63:0] l [32];
    logic [63:0] x, y;
    rk[0] = key[63:0];
    l[0]  = key[127:64];
    for (int i = 0; i < 31; i++) begin
      l[i+1]  = (rk[i] + ror64(l[i], 8)) ^ 64'(i);
      rk[i+1] = rol64(rk[i], 3) ^ l[i+1];
    end
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 32; i++) begin
      x = (ror64(x, 8) + y) ^ rk[i];
      y = rol64(y, 3) ^ x;
    end
    return {x, y};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus64.done) begin
      if (sb64.size() == 0) check("spurious_done64", 1, 0);
      else check("ct64", bus64.ciphertext, sb64.pop_front());
    end
    if (rst_n && bus16.done) begin
      if (sb16.size() == 0) check("spurious_done16", 1, 0);
      else check("ct16", {96'd0, bus16.ciphertext}, {96'd0, sb16.pop_front()});
    end
  end

  task automatic pulse64(input logic [127:0] k, input logic [127:0] p, input logic [127:0] exp);
    @(negedge clk);
    bus64.start = 1'b1;
    bus64.key = k;
    bus64.plaintext = p;
    sb64.push_back(exp);
    @(negedge clk);
    bus64.start = 1'b0;
  endtask

  task automatic wait_done64(output int busy_cycles);
    busy_cycles = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus64.done) return;
      if (bus64.busy) busy_cycles++;
      @(negedge clk);
    end
    check("timeout64", 0, 1);
  endtask

  initial begin
    int bc, nd, t1, t2, t3;
    logic [127:0] rk, rp;
    bus64.start = 1'b0; bus64.key = '0; bus64.plaintext = '0;
    bus16.start = 1'b0; bus16.key = '0; bus16.plaintext = '0;
    repeat (3) @(negedge clk);
    check("rst_ct", bus64.ciphertext, 0);
    check("rst_busy", bus64.busy, 0);
    check("rst_done", bus64.done, 0);
    check("rst_idx", bus64.round_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // vector 1: 32 busy cycles then one done
    pulse64(VEC1_KEY, VEC1_PT, VEC1_CT);
    wait_done64(bc);
    check("busy_cycles64", bc, 32);
    check("busy_at_done", bus64.busy, 0);

    // 32/64 vector
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.key = 64'h1918_1110_0908_0100;
    bus16.plaintext = 32'h6574_694c;
    sb16.push_back(32'ha868_42f2);
    @(negedge clk);
    bus16.start = 1'b0;
    bc = 0;
    for (int c = 0; c < 60 && !bus16.done; c++) begin
      if (bus16.busy) bc++;
      @(negedge clk);
    end
    check("done16", bus16.done, 1);
    check("busy_cycles16", bc, 22);

    // restarts and input changes mid-run are ignored
    pulse64(VEC1_KEY, VEC1_PT, VEC1_CT);
    for (int c = 0; c < 32; c++) begin
      check("idx_mono", bus64.round_idx, c);
      bus64.start = (c == 5 || c == 20);
      if (bus64.start) begin
        bus64.key = {$urandom, $urandom, $urandom, $urandom};
        bus64.plaintext = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
    end
    bus64.start = 1'b0;
    check("done_at_32", bus64.done, 1);
    repeat (40) @(negedge clk);

    // start held high: back-to-back blocks
    bus64.key = VEC1_KEY;
    bus64.plaintext = VEC1_PT;
    bus64.start = 1'b1;
    repeat (3) sb64.push_back(VEC1_CT);
    nd = 0; t1 = 0; t2 = 0; t3 = 0;
    for (int c = 0; c < 200 && nd < 3; c++) begin
      @(negedge clk);
      check("ct_stable", bus64.ciphertext, VEC1_CT);
      if (bus64.done) begin
        nd++;
        if (nd == 1) t1 = c;
        if (nd == 2) t2 = c;
        if (nd == 3) begin t3 = c; bus64.start = 1'b0; end
      end
    end
    bus64.start = 1'b0;
    check("held_done_count", nd, 3);
    check("done_interval_a", t2 - t1, 33);
    check("done_interval_b", t3 - t2, 33);
    repeat (40) @(negedge clk);

    // reset in mid-operation
    pulse64(VEC1_KEY, VEC1_PT, VEC1_CT);
    for (int c = 0; c < 40 && bus64.round_idx != 10; c++) @(negedge clk);
    check("reached_round10", bus64.round_idx, 10);
    rst_n = 1'b0;
    sb64.delete();
    #1;
    check("abort_ct", bus64.ciphertext, 0);
    check("abort_busy", bus64.busy, 0);
    check("abort_idx", bus64.round_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus64.done) nd++;
    end
    check("no_done_after_abort", nd, 0);
    pulse64(VEC1_KEY, VEC1_PT, VEC1_CT);
    wait_done64(bc);
    check("busy_after_abort", bc, 32);

    // random blocks against the reference model
    for (int n = 0; n < 100; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      pulse64(rk, rp, speck128_ref(rk, rp));
      wait_done64(bc);
    end
    @(negedge clk);
    check("sb64_drained", sb64.size(), 0);
    check("sb16_drained", sb16.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
